// File: rtl/fast_pow_ctrl_if.sv
// Bundle of the request/response and multiplier-side signals of fast_pow_ctrl.
// The master modport is the controller side; slave is the surrounding environment.
interface fast_pow_ctrl_if #(
  parameter int DATA_W = 260,
  parameter int EXP_W  = 256
);
  logic              start;
  logic              done;
  logic [DATA_W-1:0] result;
  logic [DATA_W-1:0] base;
  logic [DATA_W-1:0] m;
  logic [DATA_W-1:0] r1;
  logic [EXP_W-1:0]  exponent;
  logic              mul_start;
  logic [DATA_W-1:0] mul_a;
  logic [DATA_W-1:0] mul_b;
  logic [DATA_W-1:0] mul_m;
  logic [DATA_W-1:0] mul_result;
  logic              mul_done;

  modport master (
    input  start, base, m, r1, exponent, mul_result, mul_done,
    output done, result, mul_start, mul_a, mul_b, mul_m
  );

  modport slave (
    output start, base, m, r1, exponent, mul_result, mul_done,
    input  done, result, mul_start, mul_a, mul_b, mul_m
  );
endinterface

// File: rtl/fast_pow_ctrl.sv
// Right-to-left square-and-multiply sequencer driving an external Montgomery multiplier.
// Define FAST_POW_EARLY_EXIT_EN to stop iterating once the remaining exponent is zero.
module fast_pow_ctrl #(
  parameter int DATA_W = 260,
  parameter int EXP_W  = 256
) (
  input  logic           clk,
  input  logic           reset,
  fast_pow_ctrl_if.master bus
);

  localparam int CNT_W = $clog2(EXP_W + 1);

  typedef enum logic [3:0] {
    IDLE, LOAD, CHECK,
    MUL_ISSUE, MUL_WLO, MUL_WHI,
    SQ_ISSUE, SQ_WLO, SQ_WHI,
    SHIFT, FINISH
  } state_t;

  state_t            state;
  state_t            next_state;
  logic              done_q;
  logic [DATA_W-1:0] result_q;
  logic [DATA_W-1:0] mul_a_q;
  logic [DATA_W-1:0] mul_b_q;
  logic [DATA_W-1:0] mul_m_q;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] sq;
  logic [EXP_W-1:0]  e;
  logic [CNT_W-1:0]  counter;
  logic              mul_start_c;
  logic              iter_done;

`ifdef FAST_POW_EARLY_EXIT_EN
  assign iter_done = (counter == '0) || (e == '0);
`else
  assign iter_done = (counter == '0);
`endif

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (bus.start) next_state = LOAD;
      LOAD:      next_state = CHECK;
      CHECK: begin
        if (iter_done)   next_state = FINISH;
        else if (e[0])   next_state = MUL_ISSUE;
        else             next_state = SQ_ISSUE;
      end
      MUL_ISSUE: next_state = MUL_WLO;
      MUL_WLO:   if (!bus.mul_done) next_state = MUL_WHI;
      MUL_WHI:   if (bus.mul_done)  next_state = SQ_ISSUE;
      SQ_ISSUE:  next_state = SQ_WLO;
      SQ_WLO:    if (!bus.mul_done) next_state = SQ_WHI;
      SQ_WHI:    if (bus.mul_done)  next_state = SHIFT;
      SHIFT:     next_state = CHECK;
      FINISH:    next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  always_comb begin
    mul_start_c = 1'b0;
    case (state)
      MUL_ISSUE, SQ_ISSUE: mul_start_c = 1'b1;
      default:             mul_start_c = 1'b0;
    endcase
  end

  // The modulus is captured straight into mul_m_q; it never changes during a run.
  always_ff @(posedge clk) begin
    if (!reset) begin
      done_q   <= 1'b0;
      result_q <= '0;
      mul_a_q  <= '0;
      mul_b_q  <= '0;
      mul_m_q  <= '0;
      acc      <= '0;
      sq       <= '0;
      e        <= '0;
      counter  <= '0;
    end else begin
      case (state)
        IDLE: done_q <= ~bus.start;
        LOAD: begin
          acc     <= bus.r1;
          sq      <= bus.base;
          e       <= bus.exponent;
          mul_m_q <= bus.m;
          counter <= CNT_W'(EXP_W);
        end
        MUL_WHI: if (bus.mul_done) acc <= bus.mul_result;
        SQ_WHI:  if (bus.mul_done) sq  <= bus.mul_result;
        SHIFT: begin
          e       <= e >> 1;
          counter <= counter - CNT_W'(1);
        end
        FINISH: begin
          result_q <= acc;
          done_q   <= 1'b1;
        end
        default: ;
      endcase
      // Operands are latched on entry to an ISSUE state and held through its WHI.
      if (next_state == MUL_ISSUE) begin
        mul_a_q <= acc;
        mul_b_q <= sq;
      end else if (next_state == SQ_ISSUE) begin
        mul_a_q <= sq;
        mul_b_q <= sq;
      end
    end
  end

  assign bus.done      = done_q;
  assign bus.result    = result_q;
  assign bus.mul_start = mul_start_c;
  assign bus.mul_a     = mul_a_q;
  assign bus.mul_b     = mul_b_q;
  assign bus.mul_m     = mul_m_q;

endmodule

// File: tb/tb_fast_pow_ctrl.sv
// Bench for fast_pow_ctrl with a behavioural Montgomery multiplier attached.
// Expected results come from plain modular exponentiation in the normal domain.
module tb_fast_pow_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b0;

  fast_pow_ctrl_if bus();
  fast_pow_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int pulse_cnt = 0;
  int done_rises = 0;
  int dup_starts = 0;
  int extra_hold = 0;
  int max_lat = 1;

  longint unsigned m_a, m_b, m_m;
  bit  m_busy = 0, m_dropped = 0;
  int  m_hold = 0, m_lat = 0;
  logic prev_done = 1'b0;

  function automatic longint unsigned mont(longint unsigned a, longint unsigned b, longint unsigned m);
    longint unsigned t;
    t = a * b;
    for (int i = 0; i < 256; i++) begin
      if (t[0]) t = t + m;
      t = t >> 1;
    end
    if (t >= m) t = t - m;
    return t;
  endfunction

  function automatic longint unsigned pow2_mod(longint unsigned m);
    longint unsigned r;
    r = 1 % m;
    for (int i = 0; i < 256; i++) r = (r * 2) % m;
    return r;
  endfunction

  // base is in Montgomery form: convert out, exponentiate plainly, convert back
  function automatic longint unsigned ref_result(longint unsigned base, logic [255:0] e, longint unsigned m);
    longint unsigned r1, rinv, b, p;
    r1 = pow2_mod(m);
    rinv = 0;
    for (longint unsigned x = 1; x < m; x++)
      if ((r1 * x) % m == 1) begin rinv = x; break; end
    b = (base * rinv) % m;
    p = 1 % m;
    for (int i = 0; i < 256; i++) begin
      if (e[i]) p = (p * b) % m;
      b = (b * b) % m;
    end
    return (p * r1) % m;
  endfunction

  function automatic int ref_pulses(logic [255:0] e);
    int h;
    h = 0;
`ifdef FAST_POW_EARLY_EXIT_EN
    for (int i = 255; i >= 0; i--)
      if (e[i]) begin h = i + 1; break; end
`else
    h = 256;
`endif
    return h + $countones(e);
  endfunction

  // Downstream multiplier model and output monitors, evaluated mid-cycle
  initial begin
    bus.mul_done = 1'b1;
    bus.mul_result = '0;
    forever begin
      @(negedge clk);
      if (bus.mul_start === 1'b1) begin
        pulse_cnt++;
        if (m_busy) dup_starts++;
      end
      if (bus.done === 1'b1 && prev_done !== 1'b1) done_rises++;
      prev_done = bus.done;
      if (!reset) begin
        m_busy = 0;
        bus.mul_done = 1'b1;
      end else if (m_busy) begin
        if (m_hold > 0) m_hold--;
        else if (!m_dropped) begin bus.mul_done = 1'b0; m_dropped = 1; end
        else if (m_lat > 0) m_lat--;
        else begin
          bus.mul_result = 260'(mont(m_a, m_b, m_m));
          bus.mul_done = 1'b1;
          m_busy = 0;
        end
      end else if (bus.mul_start === 1'b1) begin
        m_a = bus.mul_a[63:0];
        m_b = bus.mul_b[63:0];
        m_m = bus.mul_m[63:0];
        m_busy = 1;
        m_dropped = 0;
        m_hold = extra_hold;
        m_lat = $urandom_range(max_lat, 0);
      end
    end
  end

  task automatic run_op(input longint unsigned b, input logic [255:0] e, input longint unsigned m,
                        input int mid_start, output logic [259:0] res, output int pulses,
                        output int rises, output bit to);
    int p0, d0, cnt;
    @(posedge clk); #1;
    bus.base = 260'(b);
    bus.exponent = e;
    bus.m = 260'(m);
    bus.r1 = 260'(pow2_mod(m));
    bus.start = 1'b1;
    p0 = pulse_cnt;
    d0 = done_rises;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    bus.base = '1;
    bus.exponent = ~e;
    bus.m = '1;
    bus.r1 = '1;
    cnt = 0;
    to = 0;
    while (bus.done !== 1'b1) begin
      if (cnt >= 20000) begin to = 1; break; end
      @(posedge clk); #1;
      cnt++;
      if (mid_start > 0 && cnt == mid_start) begin
        bus.start = 1'b1;
        bus.base = 260'(1);
        bus.exponent = '0;
        bus.m = 260'(m);
        bus.r1 = 260'(pow2_mod(m));
      end
      if (mid_start > 0 && cnt == mid_start + 1) bus.start = 1'b0;
    end
    bus.start = 1'b0;
    res = bus.result;
    @(negedge clk);
    pulses = pulse_cnt - p0;
    rises = done_rises - d0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    vectors++; if (bus.result !== '0) begin miscompares++; $display("FAIL reset_result: got %0h expected 0", bus.result); end
    vectors++; if (bus.mul_start !== 1'b0) begin miscompares++; $display("FAIL reset_mul_start: got %b expected 0", bus.mul_start); end
    vectors++; if (bus.mul_a !== '0 || bus.mul_m !== '0) begin miscompares++; $display("FAIL reset_operands: got %0h/%0h expected 0", bus.mul_a, bus.mul_m); end
    reset = 1'b1;
    @(posedge clk); #1;
    vectors++; if (bus.done !== 1'b1) begin miscompares++; $display("FAIL release_done: got %b expected 1", bus.done); end
  endtask

  task automatic test_directed();
    logic [259:0] res; int pulses, rises; bit to;
    logic [255:0] ex [3];
    longint unsigned want [3];
    ex[0] = 256'd10; want[0] = 4;
    ex[1] = 256'd0;  want[1] = 3;
    ex[2] = 256'd1;  want[2] = 6;
    for (int i = 0; i < 3; i++) begin
      run_op(6, ex[i], 13, 0, res, pulses, rises, to);
      vectors++;
      if (to || res !== 260'(want[i])) begin miscompares++; $display("FAIL directed_result e=%0d: got %0d expected %0d (timeout=%0d)", ex[i], res, want[i], to); end
      vectors++;
      if (pulses !== ref_pulses(ex[i])) begin miscompares++; $display("FAIL directed_pulses e=%0d: got %0d expected %0d", ex[i], pulses, ref_pulses(ex[i])); end
    end
  endtask

  task automatic test_random();
    logic [259:0] res; int pulses, rises; bit to;
    logic [255:0] e;
    longint unsigned m, b, want;
    for (int n = 0; n < 6; n++) begin
      m = 64'($urandom_range(2047, 1)) * 2 + 1;
      b = 64'($urandom_range(32'(m - 1), 0));
      for (int i = 0; i < 8; i++) e[i*32 +: 32] = $urandom();
      e = e >> $urandom_range(255, 0);
      max_lat = $urandom_range(2, 0);
      want = ref_result(b, e, m);
      run_op(b, e, m, 0, res, pulses, rises, to);
      vectors++;
      if (to || res !== 260'(want)) begin miscompares++; $display("FAIL random_result m=%0d b=%0d: got %0d expected %0d (timeout=%0d)", m, b, res, want, to); end
      vectors++;
      if (pulses !== ref_pulses(e)) begin miscompares++; $display("FAIL random_pulses m=%0d: got %0d expected %0d", m, pulses, ref_pulses(e)); end
    end
    max_lat = 1;
  endtask

  task automatic test_mid_start();
    logic [259:0] res; int pulses, rises; bit to;
    logic [255:0] e;
    longint unsigned want;
    for (int i = 0; i < 8; i++) e[i*32 +: 32] = $urandom();
    e[255] = 1'b1;
    want = ref_result(6, e, 13);
    run_op(6, e, 13, 40, res, pulses, rises, to);
    vectors++;
    if (to || res !== 260'(want)) begin miscompares++; $display("FAIL mid_start_result: got %0d expected %0d (timeout=%0d)", res, want, to); end
    vectors++;
    if (pulses !== ref_pulses(e)) begin miscompares++; $display("FAIL mid_start_pulses: got %0d expected %0d", pulses, ref_pulses(e)); end
    repeat (20) @(posedge clk);
    #1;
    vectors++;
    if (bus.done !== 1'b1 || bus.result !== 260'(want)) begin miscompares++; $display("FAIL mid_start_hold: done %b result %0d expected 1 and %0d", bus.done, bus.result, want); end
    vectors++;
    if (done_rises - (done_rises - rises) != 1 || rises != 1) begin miscompares++; $display("FAIL mid_start_done_rises: got %0d expected 1", rises); end
  endtask

  task automatic test_reset_mid();
    logic [259:0] res; int pulses, rises; bit to;
    int p0, p1, cnt;
    extra_hold = 3;
    max_lat = 0;
    @(posedge clk); #1;
    bus.base = 260'(6); bus.exponent = 256'd2; bus.m = 260'(13); bus.r1 = 260'(3);
    bus.start = 1'b1;
    p0 = pulse_cnt;
    @(posedge clk); #1;
    bus.start = 1'b0;
    cnt = 0;
    while (pulse_cnt == p0 && cnt < 100) begin @(posedge clk); #1; cnt++; end
    vectors++;
    if (cnt >= 100) begin miscompares++; $display("FAIL reset_mid_first_pulse: got %0d pulses expected 1", pulse_cnt - p0); end
    reset = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (bus.done !== 1'b0 || bus.mul_start !== 1'b0) begin miscompares++; $display("FAIL reset_mid_outputs: done %b mul_start %b expected 0 0", bus.done, bus.mul_start); end
    vectors++;
    if (bus.result !== '0) begin miscompares++; $display("FAIL reset_mid_result: got %0d expected 0", bus.result); end
    p1 = pulse_cnt;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (bus.done !== 1'b1) begin miscompares++; $display("FAIL reset_mid_release_done: got %b expected 1", bus.done); end
    repeat (5) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (pulse_cnt != p1) begin miscompares++; $display("FAIL reset_mid_no_pulses: got %0d expected 0", pulse_cnt - p1); end
    extra_hold = 0;
    max_lat = 1;
    run_op(6, 256'd10, 13, 0, res, pulses, rises, to);
    vectors++;
    if (to || res !== 260'(4)) begin miscompares++; $display("FAIL reset_mid_rerun: got %0d expected 4 (timeout=%0d)", res, to); end
  endtask

  task automatic test_slow_done();
    logic [259:0] res; int pulses, rises; bit to;
    int d0;
    extra_hold = 5;
    d0 = dup_starts;
    run_op(6, 256'd10, 13, 0, res, pulses, rises, to);
    vectors++;
    if (to || res !== 260'(4)) begin miscompares++; $display("FAIL slow_done_result: got %0d expected 4 (timeout=%0d)", res, to); end
    vectors++;
    if (pulses !== ref_pulses(256'd10)) begin miscompares++; $display("FAIL slow_done_pulses: got %0d expected %0d", pulses, ref_pulses(256'd10)); end
    vectors++;
    if (dup_starts != d0) begin miscompares++; $display("FAIL slow_done_dup_start: got %0d expected 0", dup_starts - d0); end
    extra_hold = 0;
  endtask

  initial begin
    bus.start = 1'b0;
    bus.base = '0;
    bus.exponent = '0;
    bus.m = '0;
    bus.r1 = '0;
    test_reset();
    test_directed();
    test_random();
    test_mid_start();
    test_reset_mid();
    test_slow_done();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/fast_pow_ctrl.md
FAST_POW_CTRL -- requirements
Module: fast_pow_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all logic is on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous reset, active-low (reset==0 resets the block).
REQ-003 SHALL have port start, input, 1 bit: sampled only in IDLE; 1 launches an exponentiation.
REQ-004 SHALL have port done, output reg, 1 bit: 1 while idle with result valid, 0 while busy.
REQ-005 SHALL have port result, output reg, 260 bits: base^exponent in Montgomery form, mod m.
REQ-006 SHALL have ports base, m and r1, each input, 260 bits: Montgomery-form base, odd modulus, and Montgomery one (2^256 mod m).
REQ-007 SHALL have port exponent, input, 256 bits: unsigned exponent.
REQ-008 SHALL have ports mul_start (output reg, 1 bit) and mul_a, mul_b, mul_m (output reg, 260 bits each): request to the downstream Montgomery multiplier.
REQ-009 SHALL have ports mul_result (input, 260 bits) and mul_done (input, 1 bit): response from the downstream Montgomery multiplier.

Function
REQ-010 SHALL capture base, exponent, m and r1 into internal registers in LOAD; inputs are ignored after LOAD.
REQ-011 SHALL run right-to-left square-and-multiply: acc=r1, sq=base; per iteration, if e[0] then acc=MM(acc,sq); then sq=MM(sq,sq); e>>=1.
REQ-012 SHALL use states IDLE, LOAD, CHECK, MUL_ISSUE, MUL_WLO, MUL_WHI, SQ_ISSUE, SQ_WLO, SQ_WHI, SHIFT, FINISH.
REQ-013 SHALL transition IDLE->LOAD when start=1; in IDLE, done<=start?0:1.
REQ-014 SHALL transition LOAD->CHECK, with counter<=256.
REQ-015 SHALL, in CHECK, go to FINISH if counter==0, otherwise go to MUL_ISSUE if e[0]=1, otherwise go to SQ_ISSUE.
REQ-016 SHALL, in each ISSUE state, drive mul_start=1 for exactly one cycle with operands (MUL: acc,sq,m; SQ: sq,sq,m) held stable until the matching WHI exits.
REQ-017 SHALL implement the multiplier handshake as: WLO waits for mul_done==0, then WHI waits for mul_done==1; on WHI exit, register mul_result into acc (MUL) or sq (SQ).
REQ-018 SHALL transition MUL_WHI->SQ_ISSUE and SQ_WHI->SHIFT.
REQ-019 SHALL, in SHIFT, perform e<=e>>1 and counter<=counter-1, then go to CHECK.
REQ-020 SHALL, in FINISH, set result<=acc and done<=1, then go to IDLE.
REQ-021 SHALL ignore start while not in IDLE.
REQ-022 SHALL give exponent==0 the result r1.
REQ-023 SHALL treat operands >= m and even m as outside contract; no check is made.
REQ-024 SHALL hold mul_start=0 in every state other than an ISSUE state.

Reset
REQ-025 SHALL, when reset==0, force state=IDLE and zero done, result, mul_start, mul_a, mul_b, mul_m, acc, sq, e and counter.
REQ-026 SHALL, when reset is applied mid-operation, abandon the operation with no further mul_start pulses; the downstream multiplier is reset by the same reset.
REQ-027 SHALL, on the first cycle after reset release with start==0, set done<=1.

Configuration
REQ-028 SHALL, when FAST_POW_EARLY_EXIT_EN is defined, have CHECK also go to FINISH when e==0, skipping the remaining squarings.
REQ-029 SHALL, when FAST_POW_EARLY_EXIT_EN is undefined, always run exactly 256 iterations; result is identical in both builds.

Verification (m=13, r1=3, base=6 i.e. 2 in Montgomery form, real multiplier attached)
REQ-030 SHALL cover: exponent=10 -> result=4 (2^10 mod 13 = 10, Montgomery form); 6 mul_start pulses with EARLY_EXIT, 258 without.
REQ-031 SHALL cover: exponent=0 -> result=3; 0 mul_start pulses with EARLY_EXIT, 256 without.
REQ-032 SHALL cover: exponent=1 -> result=6.
REQ-033 SHALL cover: start pulsed again mid-run -> ignored; result of the first run is unchanged, and done rises exactly once.
REQ-034 SHALL cover: reset=0 asserted during an SQ wait -> next cycle state=IDLE, done=0, mul_start=0; a fresh run with exponent=10 then returns 4.
REQ-035 SHALL cover: mul_done held high an extra 5 cycles before dropping -> controller stays in WLO, no duplicate mul_start, result correct.
